// File: rtl/sha1_round_arb_if.sv
// Handshake and engine-control bundle between two SHA-1 requesters and the round arbiter.
// The arbiter takes the slave modport; the requester/engine side takes the master modport.
interface sha1_round_arb_if #(
  parameter int T_W = 7
);
  logic [1:0]     req;
  logic [1:0]     last;
  logic [1:0]     ack;
  logic [1:0]     gnt;
  logic [1:0]     done;
  logic           load;
  logic           init;
  logic           round_en;
  logic [T_W-1:0] t;
  logic           upd;
  logic           busy;

  modport master (
    output req, last,
    input  ack, gnt, done, load, init, round_en, t, upd, busy
  );

  modport slave (
    input  req, last,
    output ack, gnt, done, load, init, round_en, t, upd, busy
  );
endinterface

// File: rtl/sha1_round_arb.sv
// Two-requester arbiter and round sequencer for a shared SHA-1 compression engine.
// Ownership is held for a whole multi-block message; all outputs are Moore-decoded.
module sha1_round_arb #(
  parameter int ROUNDS = 80,
  parameter int T_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  sha1_round_arb_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_UPD   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]     r_state;
  logic [1:0]     r_gnt;
  logic           r_ptr;
  logic           r_first;
  logic           r_last;
  logic [T_W-1:0] r_t;

  logic [1:0]     w_pick;
  logic           w_t_end;
  logic           w_load;
  logic           w_upd;

  // Round-robin only matters on a tie; a lone request always wins.
  always_comb begin
    w_pick = bus.req;
    if (bus.req == 2'b11) w_pick = r_ptr ? 2'b10 : 2'b01;
  end

  assign w_t_end = (r_t == T_W'(ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_t     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|bus.req) begin
          r_gnt   <= w_pick;
          r_first <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_last  <= |(bus.last & r_gnt);
          r_t     <= '0;
          r_state <= S_ROUND;
        end
        S_ROUND: if (w_t_end) begin
          r_t     <= '0;
          r_state <= S_UPD;
        end else begin
          r_t     <= r_t + T_W'(1);
        end
        // Final block releases the engine and hands priority to the other side.
        S_UPD: if (r_last) begin
          r_gnt   <= '0;
          r_ptr   <= r_gnt[0];
          r_state <= S_IDLE;
        end else begin
          r_first <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (|(bus.req & r_gnt)) r_state <= S_LOAD;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_load       = (r_state == S_LOAD);
  assign w_upd        = (r_state == S_UPD);

  assign bus.gnt      = r_gnt;
  assign bus.load     = w_load;
  assign bus.init     = w_load & r_first;
  assign bus.ack      = {2{w_load}} & r_gnt;
  assign bus.round_en = (r_state == S_ROUND);
  assign bus.t        = r_t;
  assign bus.upd      = w_upd;
  assign bus.done     = {2{w_upd & r_last}} & r_gnt;
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_sha1_round_arb.sv
// Bench for sha1_round_arb: directed scenarios plus random traffic, all checked
// every cycle against a block-position model of the arbiter.
module tb_sha1_round_arb;
  localparam int ROUNDS = 80;
  localparam int T_W    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sha1_round_arb_if #(.T_W(T_W)) u_if ();

  sha1_round_arb #(.ROUNDS(ROUNDS), .T_W(T_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = free), position inside the current block
  // (0 = load, 1..ROUNDS = rounds, ROUNDS+1 = update), and a between-blocks flag.
  int m_owner = -1;
  int m_pos   = 0;
  bit m_wait  = 1'b0;
  bit m_first = 1'b0;
  bit m_last  = 1'b0;
  bit m_ptr   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_pos <= 0; m_wait <= 1'b0;
      m_first <= 1'b0; m_last <= 1'b0; m_ptr <= 1'b0;
    end else if (m_owner < 0) begin
      if (u_if.req != 2'b00) begin
        if (u_if.req == 2'b11)  m_owner <= int'(m_ptr);
        else if (u_if.req[0])   m_owner <= 0;
        else                    m_owner <= 1;
        m_pos <= 0; m_wait <= 1'b0; m_first <= 1'b1;
      end
    end else if (m_wait) begin
      if (u_if.req[m_owner]) begin m_wait <= 1'b0; m_pos <= 0; end
    end else if (m_pos == 0) begin
      m_last <= u_if.last[m_owner];
      m_pos  <= 1;
    end else if (m_pos <= ROUNDS) begin
      m_pos <= m_pos + 1;
    end else if (m_last) begin
      m_owner <= -1;
      m_ptr   <= (m_owner == 0);
    end else begin
      m_wait  <= 1'b1;
      m_first <= 1'b0;
    end
  end

  logic [1:0] e_gnt;
  bit         e_act, e_load, e_ren, e_upd;
  int         e_t;

  always @(negedge clk) begin
    e_gnt  = (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
    e_act  = (m_owner >= 0) && !m_wait;
    e_load = e_act && (m_pos == 0);
    e_ren  = e_act && (m_pos >= 1) && (m_pos <= ROUNDS);
    e_upd  = e_act && (m_pos == ROUNDS + 1);
    e_t    = e_ren ? m_pos - 1 : 0;
    chk("m_gnt",      u_if.gnt,      e_gnt);
    chk("m_busy",     u_if.busy,     m_owner >= 0);
    chk("m_load",     u_if.load,     e_load);
    chk("m_init",     u_if.init,     e_load && m_first);
    chk("m_ack",      u_if.ack,      e_load ? e_gnt : 2'b00);
    chk("m_round_en", u_if.round_en, e_ren);
    chk("m_t",        u_if.t,        e_t);
    chk("m_upd",      u_if.upd,      e_upd);
    chk("m_done",     u_if.done,     (e_upd && m_last) ? e_gnt : 2'b00);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input logic [1:0] who, input string nm);
    int k = 0;
    do begin tick(); k++; end while (u_if.done == 2'b00 && k < 300);
    chk(nm, u_if.done, who);
  endtask

  task automatic wait_upd(input string nm);
    int k = 0;
    do begin tick(); k++; end while (!u_if.upd && k < 300);
    chk(nm, u_if.upd, 1);
  endtask

  initial begin
    u_if.req  = 2'b00;
    u_if.last = 2'b00;
    tick(); tick();
    chk("rst_busy", u_if.busy, 0);
    chk("rst_gnt",  u_if.gnt,  0);
    chk("rst_t",    u_if.t,    0);
    rst = 1'b0;

    // single final block from requester 0
    u_if.req = 2'b01; u_if.last = 2'b01;
    tick();
    chk("s_ack", u_if.ack, 2'b01);
    chk("s_load", u_if.load, 1);
    chk("s_init", u_if.init, 1);
    u_if.req = 2'b00;
    for (int i = 0; i < ROUNDS; i++) begin
      tick();
      chk("s_ren", u_if.round_en, 1);
      chk("s_t", u_if.t, i);
    end
    tick();
    chk("s_upd", u_if.upd, 1);
    chk("s_done", u_if.done, 2'b01);
    tick();
    chk("s_idle", u_if.busy, 0);

    // contention from a fresh reset (ptr = 0)
    rst = 1'b1; tick(); rst = 1'b0;
    u_if.req = 2'b11; u_if.last = 2'b11;
    tick();
    chk("c_gnt0", u_if.gnt, 2'b01);
    chk("c_ack0", u_if.ack, 2'b01);
    u_if.req = 2'b10;
    wait_done(2'b01, "c_done0");
    tick();
    chk("c_gap", u_if.gnt, 2'b00);
    tick();
    chk("c_gnt1", u_if.gnt, 2'b10);
    chk("c_ack1", u_if.ack, 2'b10);
    u_if.req = 2'b00;
    wait_done(2'b10, "c_done1");
    tick();
    u_if.req = 2'b11;
    tick();
    chk("c_ptr_back", u_if.gnt, 2'b01);
    u_if.req = 2'b10;
    wait_done(2'b01, "c_done2");
    tick(); tick();
    chk("c_ack3", u_if.ack, 2'b10);
    u_if.req = 2'b00;
    wait_done(2'b10, "c_done3");
    tick();

    // two-block message from requester 1
    u_if.req = 2'b10; u_if.last = 2'b00;
    tick();
    chk("m_load1", u_if.load, 1);
    chk("m_init1", u_if.init, 1);
    u_if.req = 2'b00;
    wait_upd("m_upd1");
    chk("m_nodone", u_if.done, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("m_wait_gnt", u_if.gnt, 2'b10);
    end
    u_if.req = 2'b10; u_if.last = 2'b10;
    tick();
    chk("m_load2", u_if.load, 1);
    chk("m_init2", u_if.init, 0);
    u_if.req = 2'b00;
    wait_upd("m_upd2");
    chk("m_done2", u_if.done, 2'b10);
    tick();

    // WAIT lockout against the other requester
    u_if.req = 2'b01; u_if.last = 2'b00;
    tick();
    chk("w_ack", u_if.ack, 2'b01);
    u_if.req = 2'b00;
    wait_upd("w_upd");
    u_if.req = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("w_noack", u_if.ack, 2'b00);
      chk("w_gnt", u_if.gnt, 2'b01);
    end
    u_if.req = 2'b11; u_if.last = 2'b11;
    tick();
    chk("w_load", u_if.load, 1);
    chk("w_ack0", u_if.ack, 2'b01);
    u_if.req = 2'b10;
    wait_done(2'b01, "w_done0");
    tick(); tick();
    chk("w_ack1", u_if.ack, 2'b10);
    u_if.req = 2'b00;
    wait_done(2'b10, "w_done1");
    tick();

    // reset in the middle of a block
    u_if.req = 2'b01; u_if.last = 2'b01;
    tick();
    u_if.req = 2'b00;
    begin
      int k = 0;
      do begin tick(); k++; end while (u_if.t != T_W'(40) && k < 300);
    end
    chk("r_t40", u_if.t, 40);
    #2 rst = 1'b1;
    #1;
    chk("r_busy", u_if.busy, 0);
    chk("r_gnt",  u_if.gnt,  0);
    chk("r_ren",  u_if.round_en, 0);
    chk("r_t",    u_if.t,    0);
    chk("r_done", u_if.done, 0);
    tick();
    rst = 1'b0;
    tick();
    u_if.req = 2'b01;
    tick();
    chk("r_load", u_if.load, 1);
    chk("r_init", u_if.init, 1);
    u_if.req = 2'b00;
    tick();
    chk("r_t0", u_if.t, 0);
    chk("r_ren1", u_if.round_en, 1);
    wait_done(2'b01, "r_done_ok");
    tick();

    // random traffic; requesters hold req until acked
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1; u_if.req = 2'b00;
        tick();
        rst = 1'b0;
      end else begin
        for (int r = 0; r < 2; r++) begin
          if (u_if.ack[r]) u_if.req[r] = 1'b0;
          else if (!u_if.req[r] && $urandom_range(0, 5) == 0) begin
            u_if.req[r]  = 1'b1;
            u_if.last[r] = 1'($urandom_range(0, 1));
          end
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
